// File: rtl/daq_serial_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// daq_serial_frame_receiver_if
//
// Valid/ready output stream of the DAQ serial frame receiver. One transfer
// carries one decoded frame: timestamp, channel number and ADC code.
//
// Signals:
//   out_valid      master -> slave  a decoded frame is on the bus
//   out_ready      slave  -> master consumer takes the frame this cycle
//   out_timestamp  master -> slave  frame timestamp field
//   out_channel    master -> slave  frame channel field
//   out_data       master -> slave  frame ADC code field
//
// Modports:
//   master  the receiver (drives the frame, samples ready)
//   slave   the consumer (samples the frame, drives ready)
// -----------------------------------------------------------------------------
interface daq_serial_frame_receiver_if #(
    parameter int TIMESTAMP_WIDTH = 32,
    parameter int CHANNEL_WIDTH   = 4,
    parameter int ADC_WIDTH       = 12
);
    logic                       out_valid;
    logic                       out_ready;
    logic [TIMESTAMP_WIDTH-1:0] out_timestamp;
    logic [CHANNEL_WIDTH-1:0]   out_channel;
    logic [ADC_WIDTH-1:0]       out_data;

    modport master (
        output out_valid,
        output out_timestamp,
        output out_channel,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_timestamp,
        input  out_channel,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/daq_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// daq_serial_frame_receiver
//
// Host-side receiver for the DAQ controller's serial sample stream. The three
// serial pins are synchronized into the clk domain, each frame is shifted in
// MSB first and split into timestamp / channel / ADC code. Frames whose length
// is not exactly FRAME_BITS are reported on frame_error; good frames are
// offered on a valid/ready stream through a one-entry holding register.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   serial_data    frame bit (asynchronous to clk)
//   serial_clk     bit clock, data sampled on its rising edge
//   serial_valid   high for the whole frame, falling edge ends the frame
//   out_if         valid/ready frame output (master side)
//   frame_error    one-cycle pulse for each bad-length frame
//   frame_count    good frames loaded into the holding register, wraps
//   error_count    bad-length frames, saturates at all-ones
//   overrun_count  good frames dropped because the holder was full, saturates
// -----------------------------------------------------------------------------
module daq_serial_frame_receiver #(
    parameter int TIMESTAMP_WIDTH = 32,
    parameter int CHANNEL_WIDTH   = 4,
    parameter int ADC_WIDTH       = 12,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serial_data,
    input  logic                          serial_clk,
    input  logic                          serial_valid,
    daq_serial_frame_receiver_if.master   out_if,
    output logic                          frame_error,
    output logic [31:0]                   frame_count,
    output logic [15:0]                   error_count,
    output logic [15:0]                   overrun_count
);

    localparam int FRAME_BITS = TIMESTAMP_WIDTH + CHANNEL_WIDTH + ADC_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(FRAME_BITS + 1);

    // Pin vector layout: {valid, clk, data}. The valid bit resets high so
    // that a frame already in progress when reset is released does not look
    // like a fresh rising edge; if the pin is actually low, the resulting
    // "falling edge" lands in IDLE where it is ignored.
    localparam logic [2:0] SYNC_RST = 3'b100;

    // -------------------------------------------------------------------------
    // Pin synchronizers: SYNC_STAGES flops per pin, then one edge register
    // -------------------------------------------------------------------------
    logic [2:0] pins;
    logic [2:0] sync_last;

    assign pins = {serial_valid, serial_clk, serial_data};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] stage_q;
            logic [2:0] stage_d;

            if (gi == 0) begin : g_first
                assign stage_d = pins;
            end else begin : g_chain
                assign stage_d = g_sync[gi-1].stage_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= SYNC_RST;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

    assign sync_last = g_sync[SYNC_STAGES-1].stage_q;

    logic [2:0] edge_q;
    logic [2:0] edge_d;

    assign edge_d = sync_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q <= SYNC_RST;
        end else begin
            edge_q <= edge_d;
        end
    end

    logic data_s;
    logic valid_s;
    logic valid_rise;
    logic valid_fall;
    logic sclk_rise;

    assign data_s     = sync_last[0];
    assign valid_s    = sync_last[2];
    assign valid_rise =  sync_last[2] & ~edge_q[2];
    assign valid_fall = ~sync_last[2] &  edge_q[2];
    assign sclk_rise  =  sync_last[1] & ~edge_q[1];

    // -------------------------------------------------------------------------
    // Frame FSM and output holding register
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t                     state_q,         state_d;
    logic [CNT_W-1:0]           bit_cnt_q,       bit_cnt_d;
    logic [FRAME_BITS-1:0]      shift_q,         shift_d;
    logic                       out_valid_q,     out_valid_d;
    logic [TIMESTAMP_WIDTH-1:0] timestamp_q,     timestamp_d;
    logic [CHANNEL_WIDTH-1:0]   channel_q,       channel_d;
    logic [ADC_WIDTH-1:0]       data_q,          data_d;
    logic                       frame_error_q,   frame_error_d;
    logic [31:0]                frame_count_q,   frame_count_d;
    logic [15:0]                error_count_q,   error_count_d;
    logic [15:0]                overrun_count_q, overrun_count_d;

    logic accept;
    logic frame_good;

    assign accept     = out_valid_q & out_if.out_ready;
    assign frame_good = (bit_cnt_q == FULL_CNT);

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        out_valid_d     = out_valid_q;
        timestamp_d     = timestamp_q;
        channel_d       = channel_q;
        data_d          = data_q;
        frame_error_d   = 1'b0;
        frame_count_d   = frame_count_q;
        error_count_d   = error_count_q;
        overrun_count_d = overrun_count_q;

        // A handshake empties the holder; a frame loading in CHECK below
        // overrides this in the same cycle.
        if (accept) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (valid_rise) begin
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // End of frame wins over a coincident bit-clock edge.
                if (valid_fall) begin
                    state_d = ST_CHECK;
                end else if (sclk_rise && valid_s) begin
                    if (bit_cnt_q < FULL_CNT) begin
                        shift_d   = {shift_q[FRAME_BITS-2:0], data_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        // Surplus bits only mark the frame as long.
                        bit_cnt_d = LONG_CNT;
                    end
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_good) begin
                    if (!out_valid_q || accept) begin
                        out_valid_d   = 1'b1;
                        timestamp_d   = shift_q[FRAME_BITS-1 -: TIMESTAMP_WIDTH];
                        channel_d     = shift_q[ADC_WIDTH +: CHANNEL_WIDTH];
                        data_d        = shift_q[ADC_WIDTH-1:0];
                        frame_count_d = frame_count_q + 32'd1;
                    end else if (overrun_count_q != 16'hFFFF) begin
                        overrun_count_d = overrun_count_q + 16'd1;
                    end
                end else begin
                    frame_error_d = 1'b1;
                    if (error_count_q != 16'hFFFF) begin
                        error_count_d = error_count_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            out_valid_q     <= 1'b0;
            timestamp_q     <= '0;
            channel_q       <= '0;
            data_q          <= '0;
            frame_error_q   <= 1'b0;
            frame_count_q   <= '0;
            error_count_q   <= '0;
            overrun_count_q <= '0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            out_valid_q     <= out_valid_d;
            timestamp_q     <= timestamp_d;
            channel_q       <= channel_d;
            data_q          <= data_d;
            frame_error_q   <= frame_error_d;
            frame_count_q   <= frame_count_d;
            error_count_q   <= error_count_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    assign out_if.out_valid     = out_valid_q;
    assign out_if.out_timestamp = timestamp_q;
    assign out_if.out_channel   = channel_q;
    assign out_if.out_data      = data_q;

    assign frame_error   = frame_error_q;
    assign frame_count   = frame_count_q;
    assign error_count   = error_count_q;
    assign overrun_count = overrun_count_q;

endmodule
